// File: rtl/round_ctrl.sv
// rtl/round_ctrl.sv - round sequencing controller for a memory/sequence game
//
// Purpose:
//   Tracks one game from start to WIN or LOSE. A game alternates between
//   showing the current sequence (SHOW) and letting the player reproduce it
//   (PLAY). Every correct reproduction advances the round counter. The game
//   is won when the counter reaches MAX_ROUND.
//
// Parameters:
//   MAX_ROUND       round count at which the game is won (1..15)
//   TIMEOUT_CYCLES  PLAY time limit in cycles (ROUND_TIMEOUT_EN builds only)
//
// Configuration macro:
//   ROUND_TIMEOUT_EN  when defined, a PLAY-state timer moves the game to LOSE
//                     after TIMEOUT_CYCLES cycles without a player response.
//                     When undefined, no timer exists and PLAY waits forever.
//
// Ports:
//   clock           in   rising-edge clock
//   reset           in   synchronous, active-high reset
//   start           in   pulse, begins a new game from IDLE, WIN or LOSE
//   setup_level     in   [1:0] level, captured on an accepted start
//   setup_mapa      in   [1:0] colour map, captured on an accepted start
//   show_ack        in   pulse, sequence display has finished
//   seq_done        in   pulse, player reproduced the sequence correctly
//   seq_fail        in   pulse, player made an error
//   show_req        out  high while the sequence should be displayed
//   playing         out  high while in PLAY
//   win             out  high while in WIN
//   lose            out  high while in LOSE
//   REG_SetupLEVEL  out  [1:0] captured level
//   REG_SetupMAPA   out  [1:0] captured colour map
//   round           out  [3:0] sequences completed in the current game
//   points          out  [7:0] registered {REG_SetupLEVEL, round, REG_SetupMAPA}

module round_ctrl #(
  parameter int MAX_ROUND      = 15,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] setup_level,
  input  logic [1:0] setup_mapa,
  input  logic       show_ack,
  input  logic       seq_done,
  input  logic       seq_fail,
  output logic       show_req,
  output logic       playing,
  output logic       win,
  output logic       lose,
  output logic [1:0] REG_SetupLEVEL,
  output logic [1:0] REG_SetupMAPA,
  output logic [3:0] round,
  output logic [7:0] points
);

  // Elaboration-time guard on the parameter ranges.
  if (MAX_ROUND < 1 || MAX_ROUND > 15 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("round_ctrl: MAX_ROUND must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

  localparam logic [4:0] MAX_ROUND_W = 5'(MAX_ROUND);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SHOW = 3'd1,
    S_PLAY = 3'd2,
    S_WIN  = 3'd3,
    S_LOSE = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] level_q, level_d;
  logic [1:0] mapa_q,  mapa_d;
  logic [3:0] round_q, round_d;
  logic [7:0] points_q, points_d;

  logic       start_ok;     // start is only honoured in IDLE, WIN or LOSE
  logic       done_ok;      // a correct reproduction that advances the round
  logic [4:0] round_inc;    // one wider so the compare against MAX_ROUND never wraps
  logic       timeout;      // PLAY time limit reached this cycle

  assign start_ok  = start && (state_q == S_IDLE || state_q == S_WIN || state_q == S_LOSE);
  // seq_fail wins over seq_done; the range test keeps round from ever passing MAX_ROUND.
  assign done_ok   = (state_q == S_PLAY) && seq_done && !seq_fail && ({1'b0, round_q} < MAX_ROUND_W);
  assign round_inc = {1'b0, round_q} + 5'd1;

`ifdef ROUND_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer_q, timer_d;

  // The timer is zero whenever the game is outside PLAY, so it starts from
  // zero on every entry. Every exit path from PLAY clears it again before it
  // could overflow.
  always_comb begin
    timer_d = '0;
    if (state_q == S_PLAY) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end

  // Fires on the TIMEOUT_CYCLES-th PLAY cycle, so the LOSE transition lands
  // on the edge that ends that cycle.
  assign timeout = (state_q == S_PLAY) && (timer_q == TIMEOUT_LAST);
`else
  assign timeout = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      level_q  <= 2'd0;
      mapa_q   <= 2'd0;
      round_q  <= 4'd0;
      points_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      mapa_q   <= mapa_d;
      round_q  <= round_d;
      points_q <= points_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_ok) begin
          state_d = S_SHOW;
        end
      end
      S_SHOW: begin
        if (show_ack) begin
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        if (seq_fail) begin
          state_d = S_LOSE;
        end else if (seq_done) begin
          state_d = (round_inc >= MAX_ROUND_W) ? S_WIN : S_SHOW;
        end else if (timeout) begin
          state_d = S_LOSE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: setup capture, round counter and the score word.
  always_comb begin
    level_d = level_q;
    mapa_d  = mapa_q;
    round_d = round_q;
    if (start_ok) begin
      level_d = setup_level;
      mapa_d  = setup_mapa;
      round_d = 4'd0;
    end else if (done_ok) begin
      round_d = round_inc[3:0];
    end
    // points follows the live registers with exactly one cycle of lag. Those
    // registers only move on start or seq_done, so points holds in WIN/LOSE.
    points_d = {level_q, round_q, mapa_q};
  end

  // Output decode, purely from registered state.
  always_comb begin
    show_req = (state_q == S_SHOW);
    playing  = (state_q == S_PLAY);
    win      = (state_q == S_WIN);
    lose     = (state_q == S_LOSE);
  end

  assign REG_SetupLEVEL = level_q;
  assign REG_SetupMAPA  = mapa_q;
  assign round          = round_q;
  assign points         = points_q;

endmodule

// File: tb/tb_round_ctrl.sv
// tb/tb_round_ctrl.sv - scoreboard bench for round_ctrl with a behavioural game model

module tb_round_ctrl;

  localparam int MAXR = 15;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [1:0] setup_level = 2'd0;
  logic [1:0] setup_mapa  = 2'd0;
  logic       show_ack = 1'b0;
  logic       seq_done = 1'b0;
  logic       seq_fail = 1'b0;
  logic       show_req, playing, win, lose;
  logic [1:0] REG_SetupLEVEL, REG_SetupMAPA;
  logic [3:0] round;
  logic [7:0] points;

  always #5 clock = ~clock;

  round_ctrl #(.MAX_ROUND(MAXR), .TIMEOUT_CYCLES(1000)) dut (
    .clock(clock), .reset(reset), .start(start),
    .setup_level(setup_level), .setup_mapa(setup_mapa),
    .show_ack(show_ack), .seq_done(seq_done), .seq_fail(seq_fail),
    .show_req(show_req), .playing(playing), .win(win), .lose(lose),
    .REG_SetupLEVEL(REG_SetupLEVEL), .REG_SetupMAPA(REG_SetupMAPA),
    .round(round), .points(points)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Game model: phase of play, rounds won, setup, and the score as last seen.
  typedef enum int {P_IDLE, P_SHOW, P_PLAY, P_WIN, P_LOSE} phase_t;
  phase_t m_ph = P_IDLE;
  int m_round = 0;
  int m_lvl = 0;
  int m_map = 0;
  int m_pts = 0;

  logic [19:0] exp_q[$];
  logic [19:0] mon_exp, mon_got;

  function automatic logic [19:0] model_vec();
    return {m_ph == P_SHOW, m_ph == P_PLAY, m_ph == P_WIN, m_ph == P_LOSE,
            2'(m_lvl), 2'(m_map), 4'(m_round), 8'(m_pts)};
  endfunction

  // Drive one cycle of inputs, advance the model, queue the expected outputs
  // for after the edge, and return on the following falling edge.
  task automatic step(input logic r, input logic st, input logic [1:0] lv, input logic [1:0] mp,
                      input logic ak, input logic dn, input logic fl);
    reset = r; start = st; setup_level = lv; setup_mapa = mp;
    show_ack = ak; seq_done = dn; seq_fail = fl;
    if (r) begin
      m_ph = P_IDLE; m_round = 0; m_lvl = 0; m_map = 0; m_pts = 0;
    end else begin
      // Score shows the setup/round as they stood before this edge.
      m_pts = m_lvl * 64 + m_round * 4 + m_map;
      case (m_ph)
        P_IDLE, P_WIN, P_LOSE:
          if (st) begin m_lvl = lv; m_map = mp; m_round = 0; m_ph = P_SHOW; end
        P_SHOW:
          if (ak) m_ph = P_PLAY;
        P_PLAY:
          if (fl) m_ph = P_LOSE;
          else if (dn) begin
            m_round = m_round + 1;
            m_ph = (m_round == MAXR) ? P_WIN : P_SHOW;
          end
        default: ;
      endcase
    end
    exp_q.push_back(model_vec());
    @(negedge clock);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string nm, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, expv);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation after every edge.
  always @(posedge clock) begin
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_got = {show_req, playing, win, lose, REG_SetupLEVEL, REG_SetupMAPA, round, points};
      checks++;
      if (mon_got !== mon_exp) begin
        errors++;
        $display("FAIL scoreboard cyc=%0d got=%05h expected=%05h", cyc, mon_got, mon_exp);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clock);

    // Reset state.
    step(1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b0);
    chk("reset_flags", {show_req, playing, win, lose}, 0);
    chk("reset_points", points, 0);

    // Start with level 2, map 1.
    step(1'b0, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    chk("start_show_req", show_req, 1);
    chk("start_round", round, 0);
    idle();
    chk("start_points", points, 'h81);
    chk("show_held", show_req, 1);

    // Fifteen show/done pairs win the game.
    for (int i = 0; i < MAXR; i++) begin
      step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    end
    chk("win_flag", win, 1);
    chk("win_round", round, 15);
    chk("win_show_req", show_req, 0);
    idle();
    chk("win_points", points, 'hBD);
    step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b1, 1'b0);
    chk("win_round_no_wrap", round, 15);
    chk("win_points_hold", points, 'hBD);

    // done and fail together at round 3: fail wins.
    step(1'b0, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b1);
    chk("both_lose", lose, 1);
    chk("both_round", round, 3);

    // Round 5 in PLAY: start and show_ack ignored, then reset with start high.
    step(1'b0, 1'b1, 2'd2, 2'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    end
    step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("play_start_ignored", {playing, REG_SetupLEVEL, round}, {1'b1, 2'd2, 4'd5});
    step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    chk("play_ack_ignored", playing, 1);
    step(1'b1, 1'b1, 2'd3, 2'd3, 1'b1, 1'b1, 1'b0);
    chk("reset_midgame",
        {show_req, playing, win, lose, REG_SetupLEVEL, REG_SetupMAPA, round, points}, 0);

    // Lose, then restart with level 3, map 3.
    step(1'b0, 1'b1, 2'd1, 2'd1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0, 1'b1);
    chk("lose_before_restart", lose, 1);
    step(1'b0, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("restart_round", round, 0);
    idle();
    chk("restart_points", points, 'hC3);

`ifndef ROUND_TIMEOUT_EN
    // Without the timer, PLAY waits indefinitely.
    step(1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 1'b0);
    repeat (40) idle();
    chk("play_no_timeout", playing, 1);
`endif

    // Randomised play against the model.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 7) == 0),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 19) == 0));
    end

    idle();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_ctrl.md
ROUND_CTRL -- requirements
Module: round_ctrl

Interface
REQ-001 The block SHALL have parameter MAX_ROUND, default 15, meaning the round count at which the game is won (legal range 1..15).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the PLAY-state time limit in clock cycles (used only when ROUND_TIMEOUT_EN is defined).
REQ-003 clock  in  1  single clock; all logic on its rising edge.
REQ-004 reset  in  1  reset is synchronous and active-high.
REQ-005 start  in  1  pulse; begins a new game from IDLE, WIN or LOSE.
REQ-006 setup_level  in  2  game level selection, sampled on an accepted start.
REQ-007 setup_mapa  in  2  colour-map selection, sampled on an accepted start.
REQ-008 show_ack  in  1  sequence display finished, pulse.
REQ-009 seq_done  in  1  player reproduced the current sequence correctly, pulse.
REQ-010 seq_fail  in  1  player error, pulse.
REQ-011 show_req  out  1  level request to display the current sequence.
REQ-012 playing  out  1  high while in PLAY.
REQ-013 win  out  1  high while in WIN.
REQ-014 lose  out  1  high while in LOSE.
REQ-015 REG_SetupLEVEL  out  2  latched level.
REQ-016 REG_SetupMAPA  out  2  latched map.
REQ-017 round  out  4  number of sequences completed in the current game.
REQ-018 points  out  8  registered score word {REG_SetupLEVEL, round, REG_SetupMAPA}.

Function
REQ-019 The FSM SHALL have states IDLE, SHOW, PLAY, WIN and LOSE, one-hot or encoded.
REQ-020 An accepted start in IDLE, WIN or LOSE SHALL, on the same edge, latch setup_level and setup_mapa, clear round to 0, and enter SHOW.
REQ-021 start SHALL be ignored in SHOW and PLAY.
REQ-022 show_req SHALL be high in SHOW and SHALL remain high until show_ack is sampled high, after which the next state is PLAY.
REQ-023 show_ack outside SHOW SHALL be ignored.
REQ-024 In PLAY, seq_done SHALL increment round by 1; if the new value equals MAX_ROUND the next state is WIN, otherwise SHOW.
REQ-025 In PLAY, seq_fail SHALL move to LOSE with round unchanged.
REQ-026 When seq_done and seq_fail are high in the same cycle, seq_fail SHALL take priority.
REQ-027 seq_done and seq_fail outside PLAY SHALL be ignored.
REQ-028 round SHALL never exceed MAX_ROUND and SHALL never wrap.
REQ-029 points SHALL be registered and SHALL equal {REG_SetupLEVEL, round, REG_SetupMAPA} one cycle after any change of those registers.
REQ-030 points SHALL hold its value in WIN and LOSE until the next accepted start.
REQ-031 win, lose and playing SHALL be decoded from the registered state, with no combinational path from inputs.

Reset
REQ-032 Reset SHALL force state IDLE and set every output to 0, including round, points, REG_SetupLEVEL, REG_SetupMAPA and show_req, on the next rising edge.
REQ-033 Reset asserted mid-game in any state SHALL abort the game, and reset SHALL dominate start and all other inputs in the same cycle.

Configuration
REQ-034 With macro ROUND_TIMEOUT_EN defined, a counter SHALL clear on entry to PLAY and count every PLAY cycle, and reaching TIMEOUT_CYCLES without seq_done or seq_fail SHALL move to LOSE.
REQ-035 When seq_done arrives in the same cycle the counter reaches TIMEOUT_CYCLES, seq_done SHALL take priority over the timeout.
REQ-036 Without ROUND_TIMEOUT_EN, no timer SHALL be instantiated and PLAY SHALL wait indefinitely.

Verification
REQ-037 Reset, then start with setup_level=2 and setup_mapa=1 -> SHOW, show_req=1, round=0, points=8'h81 one cycle later.
REQ-038 Run 15 cycles of show_ack followed by seq_done with MAX_ROUND=15 -> win=1, round=15, points=8'hBD, show_req=0.
REQ-039 In PLAY at round=3, drive seq_done and seq_fail in the same cycle -> lose=1, round=3.
REQ-040 Assert reset in PLAY at round=5 -> IDLE on the next edge with all outputs 0; start in PLAY and show_ack in PLAY -> no effect.
REQ-041 With ROUND_TIMEOUT_EN and TIMEOUT_CYCLES=10, idle in PLAY -> lose=1 after 10 PLAY cycles; a seq_done on cycle 10 -> SHOW instead.
REQ-042 From LOSE, start with new setup_level=3 and setup_mapa=3 -> round=0 and points=8'hC3 one cycle after entering SHOW.
